// File: rtl/imem_responder.sv
// imem_responder: dual-slot instruction store with a READ_LATENCY-deep response pipeline and flush.
module imem_responder #(
  parameter int    XLEN         = 32,
  parameter int    DEPTH_WORDS  = 1024,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            imem_ren,
  input  logic [XLEN-1:0] imem_addr0,
  input  logic [XLEN-1:0] imem_addr1,
  input  logic            flush,
`ifdef IMEM_LOAD_PORT_EN
  input  logic            load_we,
  input  logic [XLEN-1:0] load_addr,
  input  logic [XLEN-1:0] load_wdata,
`endif
  output logic [XLEN-1:0] imem_rdata0,
  output logic [XLEN-1:0] imem_rdata1,
  output logic [XLEN-1:0] imem_pc [1:0],
  output logic            imem_valid,
  output logic [1:0]      imem_fault
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'hD503201F);
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
    $error("imem_responder: READ_LATENCY must be in 1..4");
  end
  logic [XLEN-1:0] mem [DEPTH_WORDS];
  initial begin
    for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = '0;
  end
  logic [1:0][XLEN-1:0] addr, rd;
  logic [1:0]           flt;
  assign addr = {imem_addr1, imem_addr0};
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      flt[s] = addr[s][1:0] != 2'b00 || addr[s][XLEN-1:AW+2] != '0;
      rd[s]  = flt[s] ? NOP : mem[addr[s][AW+1:2]];
    end
  end
  logic                 v_q   [READ_LATENCY];
  logic [1:0][XLEN-1:0] pc_q  [READ_LATENCY];
  logic [1:0][XLEN-1:0] dat_q [READ_LATENCY];
  logic [1:0]           f_q   [READ_LATENCY];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        v_q[k]   <= 1'b0;
        pc_q[k]  <= '0;
        dat_q[k] <= '0;
        f_q[k]   <= '0;
      end
    end else begin
      v_q[0] <= imem_ren && !flush;
      if (imem_ren && !flush) begin
        pc_q[0]  <= addr;
        dat_q[0] <= rd;
        f_q[0]   <= flt;
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        v_q[k] <= v_q[k-1] && !flush;
        if (v_q[k-1] && !flush) begin
          pc_q[k]  <= pc_q[k-1];
          dat_q[k] <= dat_q[k-1];
          f_q[k]   <= f_q[k-1];
        end
      end
    end
  end
`ifdef IMEM_LOAD_PORT_EN
  always_ff @(posedge clk) begin
    if (load_we && load_addr[1:0] == 2'b00 && load_addr[XLEN-1:AW+2] == '0)
      mem[load_addr[AW+1:2]] <= load_wdata;
  end
`endif
  assign imem_valid  = v_q[READ_LATENCY-1];
  assign imem_rdata0 = dat_q[READ_LATENCY-1][0];
  assign imem_rdata1 = dat_q[READ_LATENCY-1][1];
  assign imem_pc[0]  = pc_q[READ_LATENCY-1][0];
  assign imem_pc[1]  = pc_q[READ_LATENCY-1][1];
  assign imem_fault  = f_q[READ_LATENCY-1];
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: two responders (latency 1 and 3) on shared random stimulus vs. a history-based model.
module tb_imem_responder;
  localparam int DW = 1024;
  localparam logic [31:0] NOP = 32'hD503201F;
  logic clk = 1'b0, reset = 1'b1, ren = 1'b0, flush = 1'b0;
  logic [31:0] a0 = '0, a1 = '0;
  always #5 clk = ~clk;
  logic        v_o  [2];
  logic [31:0] d0_o [2];
  logic [31:0] d1_o [2];
  logic [31:0] pc_o [2][1:0];
  logic [1:0]  f_o  [2];
  imem_responder #(.READ_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .imem_ren(ren), .imem_addr0(a0), .imem_addr1(a1), .flush(flush),
    .imem_rdata0(d0_o[0]), .imem_rdata1(d1_o[0]), .imem_pc(pc_o[0]), .imem_valid(v_o[0]), .imem_fault(f_o[0]));
  imem_responder #(.READ_LATENCY(3)) u3 (
    .clk(clk), .reset(reset), .imem_ren(ren), .imem_addr0(a0), .imem_addr1(a1), .flush(flush),
    .imem_rdata0(d0_o[1]), .imem_rdata1(d1_o[1]), .imem_pc(pc_o[1]), .imem_valid(v_o[1]), .imem_fault(f_o[1]));
  int errs = 0, checks = 0;
  task automatic chk(input string n, input int j, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s[u%0d]: got %h want %h at %0t", n, j, act, exp, $time);
    end
  endtask
  logic [31:0] mm [DW];
  function automatic logic [32:0] dec(input logic [31:0] a);
    return (a % 4 != 0 || a >= DW * 4) ? {1'b1, NOP} : {1'b0, mm[int'(a >> 2)]};
  endfunction
  // per-edge history ring: a response after edge e needs the request from edge e-L+1 with no flush/reset since
  logic        acc_r [8];
  logic        kill_r[8];
  logic [31:0] rp0 [8], rp1 [8], rd0 [8], rd1 [8];
  logic [1:0]  rf  [8];
  int          lat [2] = '{1, 3};
  int          ecnt = 0;
  bit          started = 0;
  logic        ev [2];
  logic [31:0] e0 [2], e1 [2], ep0 [2], ep1 [2];
  logic [1:0]  ef [2];
  always @(posedge clk) begin : model
    int i, s;
    bit ok;
    logic [32:0] x, y;
    i = ecnt % 8;
    x = dec(a0);
    y = dec(a1);
    kill_r[i] = reset || flush;
    acc_r[i]  = ren && !flush && !reset;
    rp0[i] = a0; rp1[i] = a1; rd0[i] = x[31:0]; rd1[i] = y[31:0]; rf[i] = {y[32], x[32]};
    if (reset) started = 1;
    for (int j = 0; j < 2; j++) begin
      if (reset) begin
        ev[j] = 0; e0[j] = '0; e1[j] = '0; ep0[j] = '0; ep1[j] = '0; ef[j] = '0;
      end else begin
        s  = ecnt - lat[j] + 1;
        ok = s >= 0 ? acc_r[s % 8] : 1'b0;
        for (int k = s + 1; k <= ecnt; k++) if (kill_r[k % 8]) ok = 0;
        ev[j] = ok;
        if (ok) begin
          e0[j] = rd0[s % 8]; e1[j] = rd1[s % 8]; ep0[j] = rp0[s % 8]; ep1[j] = rp1[s % 8]; ef[j] = rf[s % 8];
        end
      end
    end
    ecnt++;
  end
  always @(negedge clk) begin
    if (started) begin
      for (int j = 0; j < 2; j++) begin
        chk("valid", j, 32'(v_o[j]), 32'(ev[j]));
        chk("rdata0", j, d0_o[j], e0[j]);
        chk("rdata1", j, d1_o[j], e1[j]);
        chk("pc0", j, pc_o[j][0], ep0[j]);
        chk("pc1", j, pc_o[j][1], ep1[j]);
        chk("fault", j, 32'(f_o[j]), 32'(ef[j]));
      end
    end
  end
  function automatic logic [31:0] raddr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'($urandom_range(0, DW - 1) * 4 + $urandom_range(1, 3));
    if (r == 1) return $urandom_range(0, 2) == 0 ? 32'hFFFFFFFC : 32'(DW * 4 + $urandom_range(0, 255) * 4);
    if (r == 2) return 32'(DW * 4 - 4);
    return 32'($urandom_range(0, DW - 1) * 4);
  endfunction
  initial begin
    for (int i = 0; i < DW; i++) mm[i] = $urandom;
    mm[0] = 32'h11111111; mm[1] = 32'h22222222; mm[2] = 32'h33333333; mm[3] = 32'h44444444;
    #1;
    for (int i = 0; i < DW; i++) begin
      u1.mem[i] = mm[i];
      u3.mem[i] = mm[i];
    end
    repeat (3) @(negedge clk);
    chk("rst_valid", 0, 32'(v_o[0]), 0);
    chk("rst_rdata0", 1, d0_o[1], 0);
    chk("rst_pc1", 1, pc_o[1][1], 0);
    chk("rst_fault", 0, 32'(f_o[0]), 0);
    reset = 0; ren = 1; a0 = 32'h0; a1 = 32'h4;
    @(negedge clk);
    chk("basic_valid", 0, 32'(v_o[0]), 1);
    chk("basic_rdata0", 0, d0_o[0], 32'h11111111);
    chk("basic_rdata1", 0, d1_o[0], 32'h22222222);
    chk("basic_pc1", 0, pc_o[0][1], 32'h4);
    chk("basic_fault", 0, 32'(f_o[0]), 0);
    a0 = 32'h8; a1 = 32'hC;
    @(negedge clk);
    chk("b2b_rdata0", 0, d0_o[0], 32'h33333333);
    chk("b2b_lat3_early", 1, 32'(v_o[1]), 0);
    ren = 0;
    @(negedge clk);
    chk("idle_valid", 0, 32'(v_o[0]), 0);
    chk("hold_rdata0", 0, d0_o[0], 32'h33333333);
    chk("lat3_first_valid", 1, 32'(v_o[1]), 1);
    chk("lat3_first_rdata1", 1, d1_o[1], 32'h22222222);
    @(negedge clk);
    chk("lat3_second_valid", 1, 32'(v_o[1]), 1);
    chk("lat3_second_rdata0", 1, d0_o[1], 32'h33333333);
    ren = 1; a0 = 32'h2; a1 = 32'(DW * 4);
    @(negedge clk);
    chk("fault_valid", 0, 32'(v_o[0]), 1);
    chk("fault_bits", 0, 32'(f_o[0]), 3);
    chk("fault_rdata0", 0, d0_o[0], NOP);
    chk("fault_rdata1", 0, d1_o[0], NOP);
    ren = 0;
    repeat (4) @(negedge clk);
    ren = 1; a0 = 32'h0; a1 = 32'h4;
    @(negedge clk);
    a0 = 32'h4;
    @(negedge clk);
    flush = 1; a0 = 32'h8;
    @(negedge clk);
    chk("flush_t3", 1, 32'(v_o[1]), 0);
    flush = 0; a0 = 32'hC;
    @(negedge clk);
    chk("flush_t4", 1, 32'(v_o[1]), 0);
    ren = 0;
    @(negedge clk);
    chk("flush_t5", 1, 32'(v_o[1]), 0);
    @(negedge clk);
    chk("post_flush_valid", 1, 32'(v_o[1]), 1);
    chk("post_flush_rdata0", 1, d0_o[1], 32'h44444444);
    ren = 1; a0 = 32'h10; a1 = 32'h14;
    @(negedge clk);
    ren = 0; reset = 1;
    @(negedge clk);
    chk("midrst_valid", 1, 32'(v_o[1]), 0);
    chk("midrst_rdata0", 1, d0_o[1], 0);
    chk("midrst_pc0", 1, pc_o[1][0], 0);
    reset = 0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_resp", 1, 32'(v_o[1]), 0);
    end
    ren = 1;
    @(negedge clk);
    ren = 0;
    repeat (2) @(negedge clk);
    chk("postrst_valid", 1, 32'(v_o[1]), 1);
    chk("postrst_rdata1", 1, d1_o[1], mm[5]);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ren   = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 19) == 0;
      reset = $urandom_range(0, 59) == 0;
      a0    = raddr();
      a1    = $urandom_range(0, 7) == 0 ? a0 : raddr();
    end
    @(negedge clk);
    ren = 0; flush = 0; reset = 0;
    repeat (6) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
